trigger_pulse_conditioner: RTL and testbench
============================================

TRIGGER_PULSE_CONDITIONER -- requirements
Module: trigger_pulse_conditioner

Interface
REQ-001 SHALL have parameter STRETCH, default 48, pulse high time in clk cycles (1..65535).
REQ-002 SHALL have parameter HOLDOFF, default 16, forced-low gap after each pulse in clk cycles (0..65535).
REQ-003 SHALL have parameter CNT_W, default 16, width of each per-channel event counter.
REQ-004 SHALL have port clk  input  1  system clock (same clock as the processor core).
REQ-005 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port trig_in  input  4  raw trigger levels from the core's triggerout bus.
REQ-007 SHALL have port clear  input  1  synchronous clear of counters and missed flags.
REQ-008 SHALL have port trig_out  output  4  conditioned trigger pulses to GPIO header pins.
REQ-009 SHALL have port evt_count  output  4*CNT_W  packed counters; channel n at bits [n*CNT_W +: CNT_W].
REQ-010 SHALL have port missed  output  4  sticky flag per channel: edge arrived during HOLDOFF.
REQ-011 SHALL have port busy  output  1  OR of all channels not in IDLE.
REQ-012 SHALL use one clock and an asynchronous, active-low reset: clk and resetn.

Function
REQ-013 SHALL process the four channels independently with identical logic.
REQ-014 SHALL register trig_in once (t_q) and detect a rising edge as trig_in=1 with t_q=0.
REQ-015 SHALL implement per-channel states IDLE, PULSE and GAP.
REQ-016 IDLE: on an edge, SHALL enter PULSE, load the down-counter with STRETCH-1 and increment evt_count.
REQ-017 PULSE: trig_out SHALL be 1; the counter SHALL decrement each cycle; at 0 it SHALL go to GAP loaded with HOLDOFF-1, or to IDLE if HOLDOFF=0.
REQ-018 PULSE: an edge SHALL increment evt_count and SHALL NOT restart or extend the pulse.
REQ-019 GAP: trig_out SHALL be 0; the counter SHALL decrement; at 0 it SHALL go to IDLE.
REQ-020 GAP: an edge SHALL increment evt_count and set missed[n]; no pulse SHALL be produced for it.
REQ-021 trig_out[n] SHALL be registered and SHALL rise on the cycle after the edge sample (latency 2 clk from trig_in rising).
REQ-022 trig_out[n] SHALL stay high for exactly STRETCH cycles per accepted edge.
REQ-023 evt_count SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-024 clear SHALL zero evt_count and missed on the next edge of clk, without affecting state or trig_out.
REQ-025 If clear and an edge occur in the same cycle, the counter SHALL become 1, and missed SHALL become 1 if the channel is in GAP.
REQ-026 A level held high SHALL count as one edge; only 0->1 transitions SHALL count.
REQ-027 busy SHALL be registered and SHALL be high whenever any channel is in PULSE or GAP.

Reset
REQ-028 Asserting resetn low SHALL immediately force all channels to IDLE and set t_q=0, trig_out=0, evt_count=0, missed=0 and busy=0.
REQ-029 Reset asserted mid-PULSE SHALL drop trig_out asynchronously and SHALL NOT resume the pulse after release.
REQ-030 If trig_in is high when reset releases, the first clock SHALL detect it as an edge.

Verification
REQ-031 Single pulse: STRETCH=48, HOLDOFF=16; trig_in[0] 0->1 for 1 cycle -> trig_out[0] high exactly 48 cycles starting 2 cycles later; evt_count ch0=1; missed=0.
REQ-032 Retrigger: edges on ch1 at t=0 and t=10 -> one 48-cycle pulse; evt_count ch1=2; missed[1]=0.
REQ-033 Holdoff miss: edge on ch2 at t=0 and again at cycle 55 (in GAP) -> one pulse only; count=2; missed[2]=1; next edge at t=80 -> second pulse.
REQ-034 Saturation/clear: CNT_W=4; 20 accepted edges on ch3 -> count=15; clear plus a simultaneous edge -> count=1.
REQ-035 Reset mid-pulse: resetn low at cycle 20 of a pulse -> trig_out=0 at once, all outputs 0; release with trig_in[0]=1 -> new pulse, count=1.
REQ-036 Independence: simultaneous edges on all four channels -> four aligned 48-cycle pulses; each counter=1; busy high for 64 cycles.

Source files
------------

// File: rtl/trigger_pulse_conditioner.sv
// Four independent trigger conditioners: rising-edge detect, fixed-width pulse,
// forced-low holdoff gap, saturating per-channel event counters and sticky miss flags.
module trigger_pulse_conditioner #(
  parameter int unsigned STRETCH = 48,
  parameter int unsigned HOLDOFF = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [3:0]         trig_in,
  input  logic               clear,
  output logic [3:0]         trig_out,
  output logic [4*CNT_W-1:0] evt_count,
  output logic [3:0]         missed,
  output logic               busy
);

  localparam int unsigned NCH   = 4;
  localparam int unsigned TMR_W = 16;
  localparam logic [TMR_W-1:0] STRETCH_LD = TMR_W'(STRETCH - 1);
  localparam logic [TMR_W-1:0] HOLD_LD    = (HOLDOFF == 0) ? '0 : TMR_W'(HOLDOFF - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e           state_q [NCH];
  state_e           state_d [NCH];
  logic [TMR_W-1:0] tmr_q   [NCH];
  logic [TMR_W-1:0] tmr_d   [NCH];
  logic [CNT_W-1:0] cnt_q   [NCH];
  logic [CNT_W-1:0] cnt_d   [NCH];
  logic [NCH-1:0]   t_q;
  logic [NCH-1:0]   missed_q, missed_d;
  logic [NCH-1:0]   trig_out_q, trig_out_d;
  logic             busy_q, busy_d;
  logic [NCH-1:0]   rise_c;

  assign rise_c = trig_in & ~t_q;

  // Per-channel next state; trig_out and busy follow the state one cycle later.
  always_comb begin
    missed_d   = missed_q;
    trig_out_d = '0;
    busy_d     = 1'b0;
    for (int n = 0; n < NCH; n++) begin
      state_d[n] = state_q[n];
      tmr_d[n]   = tmr_q[n];
      cnt_d[n]   = clear ? '0 : cnt_q[n];
      if (clear) begin
        missed_d[n] = 1'b0;
      end
      // Clear and a coincident edge combine so the edge is never lost.
      if (rise_c[n] && (cnt_d[n] != CNT_MAX)) begin
        cnt_d[n] = cnt_d[n] + CNT_W'(1);
      end
      case (state_q[n])
        IDLE: begin
          if (rise_c[n]) begin
            state_d[n] = PULSE;
            tmr_d[n]   = STRETCH_LD;
          end
        end
        PULSE: begin
          if (tmr_q[n] == '0) begin
            if (HOLDOFF == 0) begin
              state_d[n] = IDLE;
            end else begin
              state_d[n] = GAP;
              tmr_d[n]   = HOLD_LD;
            end
          end else begin
            tmr_d[n] = tmr_q[n] - TMR_W'(1);
          end
        end
        GAP: begin
          if (rise_c[n]) begin
            missed_d[n] = 1'b1;
          end
          if (tmr_q[n] == '0) begin
            state_d[n] = IDLE;
          end else begin
            tmr_d[n] = tmr_q[n] - TMR_W'(1);
          end
        end
        default: begin
          state_d[n] = IDLE;
        end
      endcase
      trig_out_d[n] = (state_q[n] == PULSE);
      busy_d        = busy_d | (state_q[n] != IDLE);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      t_q        <= '0;
      missed_q   <= '0;
      trig_out_q <= '0;
      busy_q     <= 1'b0;
      for (int n = 0; n < NCH; n++) begin
        state_q[n] <= IDLE;
        tmr_q[n]   <= '0;
        cnt_q[n]   <= '0;
      end
    end else begin
      t_q        <= trig_in;
      missed_q   <= missed_d;
      trig_out_q <= trig_out_d;
      busy_q     <= busy_d;
      for (int n = 0; n < NCH; n++) begin
        state_q[n] <= state_d[n];
        tmr_q[n]   <= tmr_d[n];
        cnt_q[n]   <= cnt_d[n];
      end
    end
  end

  assign trig_out = trig_out_q;
  assign missed   = missed_q;
  assign busy     = busy_q;

  for (genvar g = 0; g < NCH; g++) begin : g_pack
    assign evt_count[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_trigger_pulse_conditioner.sv
// Directed bench for trigger_pulse_conditioner: cycle-indexed vector table plus
// hand sequences for pulse width, saturation/clear and reset mid-pulse.
module tb_trigger_pulse_conditioner;

  logic        clk;
  logic        resetn;
  logic [3:0]  trig_in;
  logic        clear;
  logic [3:0]  out_a;
  logic [63:0] cnt_a;
  logic [3:0]  miss_a;
  logic        busy_a;
  logic [3:0]  out_s;
  logic [15:0] cnt_s;
  logic [3:0]  miss_s;
  logic        busy_s;

  int total  = 0;
  int passed = 0;

  trigger_pulse_conditioner dut (
    .clk(clk), .resetn(resetn), .trig_in(trig_in), .clear(clear),
    .trig_out(out_a), .evt_count(cnt_a), .missed(miss_a), .busy(busy_a)
  );

  trigger_pulse_conditioner #(.CNT_W(4)) dut_sat (
    .clk(clk), .resetn(resetn), .trig_in(trig_in), .clear(clear),
    .trig_out(out_s), .evt_count(cnt_s), .missed(miss_s), .busy(busy_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned at;
    logic [3:0]  trig;
    logic        clr;
    logic [3:0]  exp_out;
    logic [3:0]  exp_miss;
    logic        exp_busy;
    logic [63:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [63:0] pk(input int c3, input int c2, input int c1, input int c0);
    return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
  endfunction

  task automatic add(input int unsigned at, input logic [3:0] trig, input logic clr,
                     input logic [3:0] eo, input logic [3:0] em, input logic eb,
                     input logic [63:0] ec);
    vec_t v;
    v.at = at; v.trig = trig; v.clr = clr;
    v.exp_out = eo; v.exp_miss = em; v.exp_busy = eb; v.exp_cnt = ec;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    resetn  = 1'b0;
    trig_in = '0;
    clear   = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c;
    int lat;
    int w;

    // at: check outputs after this edge, then drive trig/clear for the next edge
    // A: single pulse ch0
    add(0,   4'b0001, 0, 4'b0000, 4'b0000, 0, pk(0,0,0,0));
    add(1,   4'b0000, 0, 4'b0000, 4'b0000, 0, pk(0,0,0,1));
    add(2,   4'b0000, 0, 4'b0001, 4'b0000, 1, pk(0,0,0,1));
    add(49,  4'b0000, 0, 4'b0001, 4'b0000, 1, pk(0,0,0,1));
    add(50,  4'b0000, 0, 4'b0000, 4'b0000, 1, pk(0,0,0,1));
    add(65,  4'b0000, 0, 4'b0000, 4'b0000, 1, pk(0,0,0,1));
    add(66,  4'b0000, 0, 4'b0000, 4'b0000, 0, pk(0,0,0,1));
    // B: retrigger during pulse on ch1
    add(70,  4'b0010, 0, 4'b0000, 4'b0000, 0, pk(0,0,0,1));
    add(71,  4'b0000, 0, 4'b0000, 4'b0000, 0, pk(0,0,1,1));
    add(72,  4'b0000, 0, 4'b0010, 4'b0000, 1, pk(0,0,1,1));
    add(80,  4'b0010, 0, 4'b0010, 4'b0000, 1, pk(0,0,1,1));
    add(81,  4'b0000, 0, 4'b0010, 4'b0000, 1, pk(0,0,2,1));
    add(119, 4'b0000, 0, 4'b0010, 4'b0000, 1, pk(0,0,2,1));
    add(120, 4'b0000, 0, 4'b0000, 4'b0000, 1, pk(0,0,2,1));
    add(136, 4'b0000, 0, 4'b0000, 4'b0000, 0, pk(0,0,2,1));
    // C: edge during holdoff on ch2, then a later accepted edge
    add(140, 4'b0100, 0, 4'b0000, 4'b0000, 0, pk(0,0,2,1));
    add(141, 4'b0000, 0, 4'b0000, 4'b0000, 0, pk(0,1,2,1));
    add(195, 4'b0100, 0, 4'b0000, 4'b0000, 1, pk(0,1,2,1));
    add(196, 4'b0000, 0, 4'b0000, 4'b0100, 1, pk(0,2,2,1));
    add(206, 4'b0000, 0, 4'b0000, 4'b0100, 0, pk(0,2,2,1));
    add(220, 4'b0100, 0, 4'b0000, 4'b0100, 0, pk(0,2,2,1));
    add(221, 4'b0000, 0, 4'b0000, 4'b0100, 0, pk(0,3,2,1));
    add(222, 4'b0000, 0, 4'b0100, 4'b0100, 1, pk(0,3,2,1));
    add(269, 4'b0000, 0, 4'b0100, 4'b0100, 1, pk(0,3,2,1));
    add(270, 4'b0000, 0, 4'b0000, 4'b0100, 1, pk(0,3,2,1));
    // D: clear with simultaneous edges on all channels
    add(300, 4'b1111, 1, 4'b0000, 4'b0100, 0, pk(0,3,2,1));
    add(301, 4'b0000, 0, 4'b0000, 4'b0000, 0, pk(1,1,1,1));
    add(302, 4'b0000, 0, 4'b1111, 4'b0000, 1, pk(1,1,1,1));
    add(349, 4'b0000, 0, 4'b1111, 4'b0000, 1, pk(1,1,1,1));
    add(350, 4'b0000, 0, 4'b0000, 4'b0000, 1, pk(1,1,1,1));
    add(365, 4'b0000, 0, 4'b0000, 4'b0000, 1, pk(1,1,1,1));
    add(366, 4'b0000, 0, 4'b0000, 4'b0000, 0, pk(1,1,1,1));
    // E: held level counts once; clear mid-pulse leaves the pulse alone
    add(400, 4'b0001, 0, 4'b0000, 4'b0000, 0, pk(1,1,1,1));
    add(401, 4'b0001, 0, 4'b0000, 4'b0000, 0, pk(1,1,1,2));
    add(500, 4'b0000, 0, 4'b0000, 4'b0000, 0, pk(1,1,1,2));
    add(501, 4'b0001, 0, 4'b0000, 4'b0000, 0, pk(1,1,1,2));
    add(502, 4'b0001, 0, 4'b0000, 4'b0000, 0, pk(1,1,1,3));
    add(503, 4'b0001, 0, 4'b0001, 4'b0000, 1, pk(1,1,1,3));
    add(510, 4'b0001, 1, 4'b0001, 4'b0000, 1, pk(1,1,1,3));
    add(511, 4'b0001, 0, 4'b0001, 4'b0000, 1, pk(0,0,0,0));
    add(550, 4'b0001, 0, 4'b0001, 4'b0000, 1, pk(0,0,0,0));
    add(551, 4'b0001, 0, 4'b0000, 4'b0000, 1, pk(0,0,0,0));
    add(600, 4'b0000, 0, 4'b0000, 4'b0000, 0, pk(0,0,0,0));

    resetn  = 1'b0;
    trig_in = '0;
    clear   = 1'b0;
    do_reset();
    chk("reset sat cnt", 64'(cnt_s), 64'h0);
    chk("reset sat out", 64'(out_s), 64'h0);

    c = 0;
    foreach (vecs[i]) begin
      while (c < int'(vecs[i].at)) begin
        tick();
        c++;
      end
      chk($sformatf("v%0d@%0d trig_out", i, c), 64'(out_a),  64'(vecs[i].exp_out));
      chk($sformatf("v%0d@%0d missed", i, c),   64'(miss_a), 64'(vecs[i].exp_miss));
      chk($sformatf("v%0d@%0d busy", i, c),     64'(busy_a), 64'(vecs[i].exp_busy));
      chk($sformatf("v%0d@%0d evt_count", i, c), cnt_a,      vecs[i].exp_cnt);
      trig_in = vecs[i].trig;
      clear   = vecs[i].clr;
    end

    // Latency and exact width of one pulse
    do_reset();
    trig_in = 4'b0001;
    lat = 0;
    do begin
      tick();
      lat++;
      trig_in = 4'b0000;
    end while (!out_a[0] && lat < 10);
    chk("pulse latency", 64'(lat), 64'd2);
    w = 0;
    while (out_a[0] && w < 100) begin
      w++;
      tick();
    end
    chk("pulse width", 64'(w), 64'd48);
    chk("pulse count", cnt_a, pk(0,0,0,1));

    // 20 accepted edges on ch3: 4-bit counter saturates, 16-bit one does not
    do_reset();
    for (int i = 0; i < 20; i++) begin
      trig_in = 4'b1000;
      tick();
      trig_in = 4'b0000;
      repeat (69) tick();
    end
    chk("sat cnt ch3", 64'(cnt_s[15:12]), 64'd15);
    chk("wide cnt ch3", 64'(cnt_a[63:48]), 64'd20);
    chk("sat missed", 64'(miss_s), 64'h0);
    clear   = 1'b1;
    trig_in = 4'b1000;
    tick();
    clear   = 1'b0;
    trig_in = 4'b0000;
    chk("sat clear+edge", 64'(cnt_s[15:12]), 64'd1);
    chk("wide clear+edge", 64'(cnt_a[63:48]), 64'd1);

    // Reset asserted on cycle 20 of a pulse, released with trig_in high
    do_reset();
    trig_in = 4'b0001;
    tick();
    trig_in = 4'b0000;
    tick();
    repeat (19) tick();
    chk("pre-reset out", 64'(out_a), 64'h1);
    #3;
    resetn = 1'b0;
    #1;
    chk("async rst out", 64'(out_a), 64'h0);
    chk("async rst busy", 64'(busy_a), 64'h0);
    chk("async rst cnt", cnt_a, 64'h0);
    chk("async rst miss", 64'(miss_a), 64'h0);
    trig_in = 4'b0001;
    tick();
    chk("in rst out", 64'(out_a), 64'h0);
    resetn = 1'b1;
    tick();
    chk("release cnt", cnt_a, pk(0,0,0,1));
    chk("release out0", 64'(out_a), 64'h0);
    tick();
    chk("release out1", 64'(out_a), 64'h1);
    chk("release busy", 64'(busy_a), 64'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
